mc_control: RTL and testbench

Control unit for the multicycle ARM core. It holds the main instruction-sequencing FSM and the combinational instruction/ALU decode. It drives the multicycle datapath's enables and muxes, and feeds ungated write requests (RegW, MemW, NextPC, PCS, FlagW) into the conditional-execution logic, which gates them with the condition result.

---
 rtl/mc_control.sv | 143 ++++++++++++++
 tb/tb_mc_control.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle ARM control unit: the instruction-sequencing FSM plus the ALU decode.
// The state register is the only storage; every output is combinational from state and instruction fields.
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegW,
    output logic       MemW,
    output logic       NextPC,
    output logic       PCS,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_e;

    state_e state_q, state_d;
    logic   alu_op;
    logic   branch;
    logic   no_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = FETCH;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        RegW      = 1'b0;
        MemW      = 1'b0;
        NextPC    = 1'b0;
        Illegal   = 1'b0;
        alu_op    = 1'b0;
        branch    = 1'b0;
        case (state_q)
            FETCH: begin
                state_d   = DECODE;
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                state_d = Funct[0] ? MEMRD : MEMWR;
                ALUSrcB = 2'b01;
            end
            MEMRD: begin
                state_d = MEMWB;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: begin
                state_d = ALUWB;
                alu_op  = 1'b1;
            end
            EXECUTEI: begin
                state_d = ALUWB;
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            ALUWB:   RegW = ~no_write;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            UNKNOWN: Illegal = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // NoWrite comes straight from the held instruction so it still suppresses RegW in ALUWB.
    assign no_write = (Funct[4:1] == 4'b1010);

    always_comb begin
        ALUControl = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                4'b1010: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
        end
        FlagW[1] = Funct[0] & alu_op;
        FlagW[0] = Funct[0] & alu_op & ~ALUControl[1];
    end

    assign PCS    = ((Rd == 4'hF) & RegW) | branch;
    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign State  = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: per-instruction state sequences and per-state outputs
// are predicted from the instruction class and compared every cycle.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, AdrSrc, RegW, MemW, NextPC, PCS, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc, RegSrc;
    logic [3:0] State;

    int n_chk = 0;
    int n_err = 0;

    mc_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .FlagW(FlagW),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegW(RegW), .MemW(MemW),
        .NextPC(NextPC), .PCS(PCS), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Output vector: {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,FlagW,ImmSrc,RegSrc,RegW,MemW,NextPC,PCS,Illegal}
    function automatic logic [31:0] dut_vec();
        return {11'd0, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW,
                ImmSrc, RegSrc, RegW, MemW, NextPC, PCS, Illegal};
    endfunction

    function automatic logic [31:0] model_vec(input int s, input logic [1:0] op,
                                              input logic [5:0] fn, input logic [3:0] rd);
        logic       ir = 0, adr = 0, rw = 0, mw = 0, npc = 0, br = 0, ill = 0, aluop;
        logic [1:0] sa = 0, sb = 0, rs = 0, ctl = 0, fw;
        int         cmd = fn[4:1];
        aluop = (s == 6 || s == 7);
        if (aluop) begin
            if (cmd == 2 || cmd == 10) ctl = 1;
            else if (cmd == 0)         ctl = 2;
            else if (cmd == 12)        ctl = 3;
        end
        fw[1] = fn[0] & aluop;
        fw[0] = fn[0] & aluop & (ctl < 2);
        case (s)
            0: begin ir = 1; npc = 1; sa = 1; sb = 2; rs = 2; end
            1: begin sa = 1; sb = 2; rs = 2; end
            2: sb = 1;
            3: adr = 1;
            4: begin rs = 1; rw = 1; end
            5: begin adr = 1; mw = 1; end
            7: sb = 1;
            8: rw = (cmd != 10);
            9: begin sb = 1; rs = 2; br = 1; end
            10: ill = 1;
            default: ;
        endcase
        return {11'd0, ir, adr, sa, sb, rs, ctl, fw, op, (op == 2'b01), (op == 2'b10),
                rw, mw, npc, (rw & (rd == 4'hF)) | br, ill};
    endfunction

    // Run one instruction from FETCH, checking every cycle; leaves the bench in the next FETCH.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
        int seq[$];
        Op = op; Funct = fn; Rd = rd;
        case (op)
            2'b01:   seq = fn[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b00:   seq = '{0, 1, (fn[5] ? 7 : 6), 8};
            2'b10:   seq = '{0, 1, 9};
            default: seq = '{0, 1, 10};
        endcase
        foreach (seq[i]) begin
            #1;
            chk($sformatf("state op%0d f%02h step%0d", op, fn, i), State, seq[i]);
            chk($sformatf("outs op%0d f%02h st%0d", op, fn, seq[i]), dut_vec(),
                model_vec(seq[i], op, fn, rd));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("back to fetch", State, 0);
    endtask

    initial begin
        reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset state", State, 0);
        chk("reset outs", dut_vec(), model_vec(0, 2'b00, 6'd0, 4'd0));
        reset = 1'b1;
        #1 chk("held until edge", State, 0);
        @(posedge clk); @(negedge clk);
        chk("first edge decode", State, 1);
        // Pulse reset between edges to return to FETCH with the bench at mid-cycle.
        reset = 1'b0;
        #1 chk("async to fetch", State, 0);
        #1 reset = 1'b1;

        run_instr(2'b01, 6'b011001, 4'd2);   // LDR
        run_instr(2'b01, 6'b011000, 4'd2);   // STR
        run_instr(2'b00, 6'b001001, 4'd3);   // ADDS reg
        run_instr(2'b00, 6'b110101, 4'd0);   // CMP imm
        run_instr(2'b00, 6'b011000, 4'hF);   // ORR to PC
        run_instr(2'b01, 6'b011001, 4'hF);   // LDR to PC
        run_instr(2'b10, 6'b100000, 4'd0);   // B
        run_instr(2'b11, 6'b000000, 4'd0);   // illegal

        // Abort an LDR in MEMRD.
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("reached memrd", State, 3);
        reset = 1'b0;
        #1;
        chk("abort state", State, 0);
        chk("abort no writes", {RegW, MemW}, 2'b00);
        @(posedge clk); @(negedge clk);
        chk("stays in reset", State, 0);
        #1 reset = 1'b1;

        for (int k = 0; k < 80; k++)
            run_instr(2'($urandom), 6'($urandom), 4'($urandom));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
